// File: rtl/bus_arbiter.sv
// CPU / 8237 DMA bus ownership arbiter with dead-clock handovers and a
// post-DMA CPU starvation guard. All outputs are registered Moore decodes.
module bus_arbiter #(
    parameter int unsigned handover_clocks = 2,
    parameter int unsigned min_cpu_clocks  = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic dma_hold_request,
    input  logic cpu_cycle_idle,
    input  logic cpu_lock_n,
    output logic cpu_hold,
    output logic dma_hold_acknowledge,
    output logic address_enable_n,
    output logic dma_owner
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] S_CPU_OWN     = 3'd0;
    localparam logic [ST_W-1:0] S_CPU_RELEASE = 3'd1;
    localparam logic [ST_W-1:0] S_HANDOVER    = 3'd2;
    localparam logic [ST_W-1:0] S_DMA_OWN     = 3'd3;
    localparam logic [ST_W-1:0] S_RETURN      = 3'd4;

    localparam logic [CNT_W-1:0] HO_LOAD    = CNT_W'(handover_clocks);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(min_cpu_clocks);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Elaboration-time range check on the timing parameters.
    generate
        if (handover_clocks < 1 || handover_clocks > 255) begin : g_bad_ho
            $error("bus_arbiter: handover_clocks out of range 1..255");
        end
        if (min_cpu_clocks > 255) begin : g_bad_guard
            $error("bus_arbiter: min_cpu_clocks out of range 0..255");
        end
    endgenerate

    logic [ST_W-1:0]  r_state;
    logic [CNT_W-1:0] r_guard;
    logic [CNT_W-1:0] r_ho_cnt;
    logic             r_cpu_hold;
    logic             r_hlda;
    logic             r_aen_n;
    logic             r_owner;

    logic [ST_W-1:0]  w_next_state;
    logic [CNT_W-1:0] w_next_guard;
    logic [CNT_W-1:0] w_next_ho_cnt;
    logic             w_next_cpu_hold;
    logic             w_next_hlda;
    logic             w_next_aen_n;
    logic             w_next_owner;
    logic             w_ho_expired;

    // A count of 0 is treated as expiry too, so a corrupted counter cannot wedge the FSM.
    assign w_ho_expired = (r_ho_cnt <= CNT_ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_CPU_OWN;
            r_guard    <= '0;
            r_ho_cnt   <= '0;
            r_cpu_hold <= 1'b0;
            r_hlda     <= 1'b0;
            r_aen_n    <= 1'b0;
            r_owner    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_guard    <= w_next_guard;
            r_ho_cnt   <= w_next_ho_cnt;
            r_cpu_hold <= w_next_cpu_hold;
            r_hlda     <= w_next_hlda;
            r_aen_n    <= w_next_aen_n;
            r_owner    <= w_next_owner;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_guard    = r_guard;
        w_next_ho_cnt   = r_ho_cnt;
        w_next_cpu_hold = 1'b0;
        w_next_hlda     = 1'b0;
        w_next_aen_n    = 1'b0;
        w_next_owner    = 1'b0;

        case (r_state)
            S_CPU_OWN: begin
                if (r_guard != '0) begin
                    w_next_guard = r_guard - CNT_ONE;
                end else if (dma_hold_request) begin
                    w_next_state = S_CPU_RELEASE;
                end
            end
            S_CPU_RELEASE: begin
                if (!dma_hold_request) begin
                    w_next_state = S_CPU_OWN;
                end else if (cpu_cycle_idle && cpu_lock_n) begin
                    w_next_state  = S_HANDOVER;
                    w_next_ho_cnt = HO_LOAD;
                end
            end
            S_HANDOVER: begin
                // Never aborted mid-count; a withdrawn request is seen only at expiry.
                if (w_ho_expired) begin
                    if (dma_hold_request) begin
                        w_next_state = S_DMA_OWN;
                    end else begin
                        w_next_state  = S_RETURN;
                        w_next_ho_cnt = HO_LOAD;
                    end
                end else begin
                    w_next_ho_cnt = r_ho_cnt - CNT_ONE;
                end
            end
            S_DMA_OWN: begin
                if (!dma_hold_request) begin
                    w_next_state  = S_RETURN;
                    w_next_ho_cnt = HO_LOAD;
                end
            end
            S_RETURN: begin
                if (w_ho_expired) begin
                    w_next_state = S_CPU_OWN;
                    w_next_guard = GUARD_LOAD;
                end else begin
                    w_next_ho_cnt = r_ho_cnt - CNT_ONE;
                end
            end
            default: begin
                w_next_state  = S_CPU_OWN;
                w_next_guard  = '0;
                w_next_ho_cnt = '0;
            end
        endcase

        // Outputs are decoded from the state being entered so they flip with it.
        case (w_next_state)
            S_CPU_RELEASE: begin
                w_next_cpu_hold = 1'b1;
            end
            S_HANDOVER, S_RETURN: begin
                w_next_cpu_hold = 1'b1;
                w_next_aen_n    = 1'b1;
                w_next_owner    = 1'b1;
            end
            S_DMA_OWN: begin
                w_next_cpu_hold = 1'b1;
                w_next_hlda     = 1'b1;
                w_next_aen_n    = 1'b1;
                w_next_owner    = 1'b1;
            end
            default: begin
                w_next_cpu_hold = 1'b0;
                w_next_hlda     = 1'b0;
                w_next_aen_n    = 1'b0;
                w_next_owner    = 1'b0;
            end
        endcase
    end

    assign cpu_hold             = r_cpu_hold;
    assign dma_hold_acknowledge = r_hlda;
    assign address_enable_n     = r_aen_n;
    assign dma_owner            = r_owner;

endmodule
